// File: rtl/i281_program_loader.sv
// i281_program_loader
// Receives a framed byte stream (count, N hi/lo word pairs, XOR checksum)
// over a valid/ready handshake and writes the assembled words sequentially
// into code memory. The CPU run enable is held low while a frame is loading
// and in the error state.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-low reset
//   run_req     user run request, gated onto cpu_run
//   start_load  level; begins a frame when sampled in IDLE/DONE/ERR
//   rx_valid    byte available on rx_data
//   rx_data     incoming byte
//   rx_ready    loader accepts a byte this cycle
//   cm_we       code memory write strobe (one-cycle pulse)
//   cm_addr     code memory write address
//   cm_wdata    code memory write data {hi, lo}
//   cpu_run     registered run enable to the CPU
//   busy        high in any load state
//   done        last frame loaded with a good checksum
//   error       last frame had a checksum mismatch
module i281_program_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_req,
  input  logic              start_load,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              cm_we,
  output logic [ADDR_W-1:0] cm_addr,
  output logic [WORD_W-1:0] cm_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so a full-memory frame (count field 0) can hold 64.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] remaining;
  logic [7:0]       hi_byte;
  logic [7:0]       checksum;

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    cm_we    = 1'b0;
    busy     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_load) state_n = S_HDR;
      end
      S_HDR: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = S_HI;
      end
      S_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = S_WRITE;
      end
      S_WRITE: begin
        cm_we   = 1'b1;
        busy    = 1'b1;
        state_n = (remaining == CNT_W'(1)) ? S_CHK : S_HI;
      end
      S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_n = (rx_data == checksum) ? S_DONE : S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      hi_byte   <= '0;
      checksum  <= '0;
      cm_addr   <= '0;
      cm_wdata  <= '0;
      cpu_run   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_n;
      // Driven from the next state so cpu_run drops on the very first
      // load cycle rather than one cycle into the frame.
      cpu_run <= run_req && ((state_n == S_IDLE) || (state_n == S_DONE));
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_load) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cm_addr  <= '0;
            checksum <= '0;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            remaining <= (rx_data[ADDR_W-1:0] == '0) ? FULL_CNT
                                                     : {1'b0, rx_data[ADDR_W-1:0]};
          end
        end
        S_HI: begin
          if (rx_valid) begin
            hi_byte  <= rx_data;
            checksum <= checksum ^ rx_data;
          end
        end
        S_LO: begin
          if (rx_valid) begin
            cm_wdata <= {hi_byte, rx_data};
            checksum <= checksum ^ rx_data;
          end
        end
        S_WRITE: begin
          cm_addr   <= cm_addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
        end
        S_CHK: begin
          if (rx_valid) begin
            done  <= (rx_data == checksum);
            error <= (rx_data != checksum);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i281_program_loader.sv
module tb_i281_program_loader;

  logic        clock;
  logic        reset;
  logic        run_req;
  logic        start_load;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cm_we;
  logic [5:0]  cm_addr;
  logic [15:0] cm_wdata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        error;

  i281_program_loader #(
    .ADDR_W(6),
    .WORD_W(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run_req   (run_req),
    .start_load(start_load),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cm_we     (cm_we),
    .cm_addr   (cm_addr),
    .cm_wdata  (cm_wdata),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_w[$];   // expected code-memory writes, in order
  logic [1:0]  exp_s[$];   // expected {done, error} at end of each frame
  logic [15:0] words[64];  // payload of the frame being sent

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples just after each rising edge, pops the scoreboard.
  bit  prev_busy = 1'b0;
  wr_t mon_e;
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      check("we_during_reset", cm_we, 0);
    end else begin
      if (cm_we) begin
        check("rx_ready_in_write", rx_ready, 0);
        if (exp_w.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_w.pop_front();
          check("write_addr", cm_addr, mon_e.a);
          check("write_data", cm_wdata, mon_e.d);
        end
      end
      if (busy) check("cpu_run_while_busy", cpu_run, 0);
      if (prev_busy && !busy) begin
        check("writes_left_at_end", exp_w.size(), 0);
        if (exp_s.size() == 0) check("unexpected_frame_end", 1, 0);
        else check("frame_status", {done, error}, exp_s.pop_front());
      end
    end
    prev_busy = busy;
  end

  // Present one byte, optionally with random rx_valid gaps and random
  // start_load noise; returns once the byte is accepted at the next edge.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int unsigned guard = 0;
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clock);
      rx_valid   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data    = rx_valid ? b : 8'($urandom);
      start_load = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rx_valid && rx_ready) begin
        sent = 1'b1;
      end else begin
        guard++;
        if (guard > 500) begin
          check("byte_accept_timeout", 1, 0);
          sent = 1'b1;
        end
      end
    end
  endtask

  // Reference model: frame n words of words[], expected writes go to
  // addresses 0..n-1, checksum is the XOR of all data bytes.
  task automatic run_frame(input int unsigned n, input logic [7:0] delta, input bit stall);
    logic [7:0]  chk = '0;
    logic [1:0]  top;
    logic [7:0]  cnt;
    int unsigned g;
    wr_t         w;
    top = 2'($urandom);
    cnt = {top, 6'(n)};
    for (int unsigned i = 0; i < n; i++) begin
      w.a = 6'(i);
      w.d = words[i];
      exp_w.push_back(w);
      chk = chk ^ words[i][15:8] ^ words[i][7:0];
    end
    exp_s.push_back((delta == 8'h00) ? 2'b10 : 2'b01);
    @(negedge clock);
    start_load = 1'b1;
    send_byte(cnt, stall);
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(words[i][15:8], stall);
      send_byte(words[i][7:0], stall);
    end
    send_byte(chk ^ delta, stall);
    @(negedge clock);
    rx_valid   = 1'b0;
    start_load = 1'b0;
    g = 0;
    while (busy && g < 20) begin
      @(negedge clock);
      g++;
    end
    check("frame_end_busy", busy, 0);
    @(negedge clock);
    check("cpu_run_after_frame", cpu_run, run_req & (delta == 8'h00));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    wr_t        w;
    reset = 1'b0; run_req = 1'b1; start_load = 1'b0; rx_valid = 1'b0; rx_data = '0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_outputs", {rx_ready, cm_we, cm_addr, cm_wdata, cpu_run, busy, done, error}, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_release_cpu_run", cpu_run, 1);
    check("rst_release_busy", busy, 0);

    // Basic load, checksum 0x40
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_frame(2, 8'h00, 1'b0);
    check("basic_done", done, 1);

    // Bad checksum 0x41: words still written, error raised
    run_frame(2, 8'h01, 1'b0);
    check("bad_error", error, 1);
    check("bad_cpu_run", cpu_run, 0);

    // Full memory (count byte 0 means 64 words)
    for (int unsigned i = 0; i < 64; i++) words[i] = 16'($urandom);
    run_frame(64, 8'h00, 1'b0);

    // Backpressure with random stalls
    for (int unsigned i = 0; i < 3; i++) words[i] = 16'($urandom);
    run_frame(3, 8'h00, 1'b1);

    // Random frames
    for (int unsigned k = 0; k < 10; k++) begin
      int unsigned n;
      n = $urandom_range(1, 20);
      for (int unsigned i = 0; i < n; i++) words[i] = 16'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_req = 1'($urandom_range(0, 1));
      run_frame(n, d, 1'($urandom_range(0, 1)));
    end
    run_req = 1'b1;

    // Reset mid-load, after the high byte of word 1
    words[0] = 16'($urandom);
    words[1] = 16'($urandom);
    w.a = 6'd0;
    w.d = words[0];
    exp_w.push_back(w);
    @(negedge clock);
    start_load = 1'b1;
    send_byte(8'd3, 1'b0);
    send_byte(words[0][15:8], 1'b0);
    send_byte(words[0][7:0], 1'b0);
    send_byte(words[1][15:8], 1'b0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_outputs", {rx_ready, cm_we, cm_addr, cm_wdata, cpu_run, busy, done, error}, 0);
    check("midrst_word0_written", exp_w.size(), 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("midrst_busy", busy, 0);

    // Fresh frame after reset starts at address 0
    words[0] = 16'($urandom);
    words[1] = 16'($urandom);
    run_frame(2, 8'h00, 1'b0);

    repeat (3) @(negedge clock);
    check("final_writes_left", exp_w.size(), 0);
    check("final_status_left", exp_s.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
